clock_time_keeper: RTL and testbench
====================================

# clock_time_keeper

Time-of-day core for the VGA clock: divides the 25 MHz system clock to a 1 Hz tick, keeps hours/minutes/seconds in BCD (24-hour format), and applies set commands from the debounced button pulses. Sits directly downstream of the button debouncers and upstream of the digit-rendering logic, which reads the BCD outputs.

## Interface

Parameters:
- CLK_HZ, 25_000_000, regular_clk cycles per second; prescaler terminal count is CLK_HZ-1; must be ≥ 2

Ports:
- regular_clk  in  1  system clock, 25 MHz
- reset  in  1  asynchronous, active-high reset
- hour_btn  in  1  debounced hour-set pulse from debouncer output_pulse
- min_btn  in  1  debounced minute-set pulse
- sec_btn  in  1  debounced seconds-clear pulse
- hours_tens  out  2  BCD 0..2
- hours_units  out  4  BCD 0..9 (0..3 when hours_tens = 2)
- min_tens  out  3  BCD 0..5
- min_units  out  4  BCD 0..9
- sec_tens  out  3  BCD 0..5
- sec_units  out  4  BCD 0..9
- sec_tick  out  1  one-cycle strobe, high in the cycle the seconds field advances

One clock; reset is asynchronous and active-high.

## Operation

- Edge detection: each *_btn input is registered once; an event is (btn & ~btn_q). A level held high for N cycles produces exactly one event. Edge registers reset to 0, so a button held high through reset release produces one event on the first cycle after release.
- Prescaler: width $clog2(CLK_HZ); counts 0..CLK_HZ-1 and wraps to 0. tick = (prescaler == CLK_HZ-1).
- Seconds: on tick, advance sec_units; 9→0 with carry into sec_tens; 59→00 raises sec_carry.
- Minutes: on sec_carry, advance; 59→00 raises min_carry.
- Hours: on min_carry, advance; 09→10, 19→20, 23→00.
- sec event: clears seconds to 00 and prescaler to 0; this overrides tick in the same cycle (no seconds advance, no sec_carry, sec_tick stays low).
- min event: advances minutes by exactly one, 59→00, with no carry into hours. If sec_carry occurs in the same cycle, minutes still advance by exactly one.
- hour event: advances hours by exactly one, 23→00. If min_carry occurs in the same cycle, hours still advance by exactly one.
- Simultaneous events on different buttons are all applied in the same cycle, each with the rules above.
- The BCD fields never hold an illegal value: each digit is compared against its terminal digit, never against the binary sum.

## Timing

- Reset (asynchronous): all outputs 0, i.e. 00:00:00 and sec_tick=0. Prescaler and edge registers are 0.
- All outputs are registered; no combinational path from any input to any output.
- Latency from a btn rising edge to the updated field is 2 cycles: edge register, then field register.
- The first sec_tick after reset release occurs CLK_HZ cycles after the first non-reset edge. Ticks then repeat every CLK_HZ cycles.
- sec_tick is asserted in the same cycle the updated seconds value appears.
- Rollover 23:59:59→00:00:00 completes in one cycle: all digits update on the same edge.
- Reset asserted mid-count clears everything immediately, without waiting for a clock edge.

## Test plan

- Reset/tick (CLK_HZ=4): release reset → sec_tick every 4 cycles; after 4 ticks the time reads 00:00:04; all outputs 0 while reset is high.
- Full rollover (CLK_HZ=4): run from reset to 23:59:59 (preload by 23 hour pulses, 59 min pulses, 59×4 cycles) → next tick reads 00:00:00, with one sec_tick.
- Minute set, no carry: at 12:59:xx pulse min_btn → 12:00:xx; hours unchanged. Hold min_btn high for 50 cycles → exactly one increment.
- Hour set wrap: at 23:xx pulse hour_btn → 00:xx; at 09 → 10; at 19 → 20.
- Seconds clear vs tick (CLK_HZ=4): sec_btn event in the same cycle as tick at 00:00:37 → 00:00:00, sec_tick low, next tick exactly 4 cycles later.
- Coincident carry + set: at 00:05:59, min_btn event in the same cycle as tick → 00:06:00 (not 00:07); hour_btn with min_carry at 03:59:59 → 04:00:00.

Source files
------------

// File: rtl/clock_time_keeper.sv
// clock_time_keeper
//   Time-of-day core for the VGA clock. Divides regular_clk down to a 1 Hz
//   tick and keeps 24-hour time in BCD. It also applies the set/clear
//   commands that come from the debounced buttons.
//
// Ports
//   regular_clk      system clock (CLK_HZ cycles per second)
//   reset            asynchronous, active-high reset
//   hour_btn         hour-set pulse: advances hours by one, 23 -> 00
//   min_btn          minute-set pulse: advances minutes by one, no carry out
//   sec_btn          seconds-clear pulse: seconds and prescaler go to 0
//   hours_tens/units BCD hours 00..23
//   min_tens/units   BCD minutes 00..59
//   sec_tens/units   BCD seconds 00..59
//   sec_tick         one-cycle strobe, high in the cycle the new seconds value appears
module clock_time_keeper #(
    parameter int CLK_HZ = 25_000_000
) (
    input  logic       regular_clk,
    input  logic       reset,
    input  logic       hour_btn,
    input  logic       min_btn,
    input  logic       sec_btn,
    output logic [1:0] hours_tens,
    output logic [3:0] hours_units,
    output logic [2:0] min_tens,
    output logic [3:0] min_units,
    output logic [2:0] sec_tens,
    output logic [3:0] sec_units,
    output logic       sec_tick
);
    localparam int            PW     = $clog2(CLK_HZ);
    localparam logic [PW-1:0] PRE_TC = PW'(CLK_HZ - 1);

    // Button order inside the vectors: [2]=hour, [1]=min, [0]=sec.
    logic [2:0]    btn_q;
    logic [2:0]    ev_q, ev_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [1:0]    hr_t_q, hr_t_d;
    logic [3:0]    hr_u_q, hr_u_d;
    logic [2:0]    mn_t_q, mn_t_d;
    logic [3:0]    mn_u_q, mn_u_d;
    logic [2:0]    sc_t_q, sc_t_d;
    logic [3:0]    sc_u_q, sc_u_d;
    logic          tick_q, tick_d;

    logic tick, sec_carry, min_carry;
    logic hour_ev, min_ev, sec_ev;

    // The rising-edge event is registered before it is used. This gives the
    // two-cycle button-to-field latency, and it keeps every output a
    // register away from the inputs.
    assign ev_d    = {hour_btn, min_btn, sec_btn} & ~btn_q;
    assign hour_ev = ev_q[2];
    assign min_ev  = ev_q[1];
    assign sec_ev  = ev_q[0];
    assign tick    = (pre_q == PRE_TC);

    always_comb begin
        pre_d     = tick ? '0 : pre_q + 1'b1;
        sc_t_d    = sc_t_q;
        sc_u_d    = sc_u_q;
        mn_t_d    = mn_t_q;
        mn_u_d    = mn_u_q;
        hr_t_d    = hr_t_q;
        hr_u_d    = hr_u_q;
        sec_carry = 1'b0;
        min_carry = 1'b0;

        // Seconds: a clear beats the tick and swallows its carry.
        if (sec_ev) begin
            pre_d  = '0;
            sc_t_d = '0;
            sc_u_d = '0;
        end else if (tick) begin
            if (sc_u_q == 4'd9) begin
                sc_u_d = '0;
                if (sc_t_q == 3'd5) begin
                    sc_t_d    = '0;
                    sec_carry = 1'b1;
                end else begin
                    sc_t_d = sc_t_q + 1'b1;
                end
            end else begin
                sc_u_d = sc_u_q + 1'b1;
            end
        end

        // Minutes: a set and a carry together still give a single step. A set
        // never carries into hours.
        if (min_ev || sec_carry) begin
            if (mn_u_q == 4'd9) begin
                mn_u_d = '0;
                if (mn_t_q == 3'd5) begin
                    mn_t_d    = '0;
                    min_carry = ~min_ev;
                end else begin
                    mn_t_d = mn_t_q + 1'b1;
                end
            end else begin
                mn_u_d = mn_u_q + 1'b1;
            end
        end

        // Hours: a set and a carry together still give a single step.
        if (hour_ev || min_carry) begin
            if (hr_t_q == 2'd2 && hr_u_q == 4'd3) begin
                hr_t_d = '0;
                hr_u_d = '0;
            end else if (hr_u_q == 4'd9) begin
                hr_u_d = '0;
                hr_t_d = hr_t_q + 1'b1;
            end else begin
                hr_u_d = hr_u_q + 1'b1;
            end
        end
    end

    assign tick_d = tick & ~sec_ev;

    always_ff @(posedge regular_clk or posedge reset) begin
        if (reset) begin
            btn_q  <= '0;
            ev_q   <= '0;
            pre_q  <= '0;
            sc_t_q <= '0;
            sc_u_q <= '0;
            mn_t_q <= '0;
            mn_u_q <= '0;
            hr_t_q <= '0;
            hr_u_q <= '0;
            tick_q <= 1'b0;
        end else begin
            btn_q  <= {hour_btn, min_btn, sec_btn};
            ev_q   <= ev_d;
            pre_q  <= pre_d;
            sc_t_q <= sc_t_d;
            sc_u_q <= sc_u_d;
            mn_t_q <= mn_t_d;
            mn_u_q <= mn_u_d;
            hr_t_q <= hr_t_d;
            hr_u_q <= hr_u_d;
            tick_q <= tick_d;
        end
    end

    assign hours_tens  = hr_t_q;
    assign hours_units = hr_u_q;
    assign min_tens    = mn_t_q;
    assign min_units   = mn_u_q;
    assign sec_tens    = sc_t_q;
    assign sec_units   = sc_u_q;
    assign sec_tick    = tick_q;
endmodule

// File: tb/tb_clock_time_keeper.sv
module tb_clock_time_keeper;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       hour_btn = 1'b0, min_btn = 1'b0, sec_btn = 1'b0;
    logic [1:0] hours_tens;
    logic [3:0] hours_units, min_units, sec_units;
    logic [2:0] min_tens, sec_tens;
    logic       sec_tick;

    int total = 0;
    int bad   = 0;

    clock_time_keeper #(.CLK_HZ(4)) dut (
        .regular_clk(clk), .reset(reset),
        .hour_btn(hour_btn), .min_btn(min_btn), .sec_btn(sec_btn),
        .hours_tens(hours_tens), .hours_units(hours_units),
        .min_tens(min_tens), .min_units(min_units),
        .sec_tens(sec_tens), .sec_units(sec_units),
        .sec_tick(sec_tick)
    );

    always #5 clk = ~clk;

    // Time packed as decimal hhmmss.
    function automatic int tod();
        return hours_tens * 100000 + hours_units * 10000 + min_tens * 1000
             + min_units * 100 + sec_tens * 10 + sec_units;
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Step n rising edges, then settle 1 time unit past the edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // n single-cycle pulses on a button (0=hour, 1=min, 2=sec), 2 cycles each.
    task automatic pulse(input int which, input int n);
        for (int i = 0; i < n; i++) begin
            case (which)
                0: hour_btn = 1'b1;
                1: min_btn  = 1'b1;
                default: sec_btn = 1'b1;
            endcase
            step(1);
            hour_btn = 1'b0; min_btn = 1'b0; sec_btn = 1'b0;
            step(1);
        end
    endtask

    initial begin
        // Reset and basic ticking
        step(2);
        chk("rst_tod", tod(), 0);
        chk("rst_tick", sec_tick, 0);
        reset = 1'b0;
        step(3);
        chk("pre_first_tick", sec_tick, 0);
        chk("pre_first_tod", tod(), 0);
        step(1);
        chk("first_tick", sec_tick, 1);
        chk("first_tod", tod(), 1);
        step(1);
        chk("tick_one_cycle", sec_tick, 0);
        step(11);
        chk("four_ticks_tod", tod(), 4);
        chk("fourth_tick", sec_tick, 1);

        // Preload to 23:59:59, then roll over
        pulse(0, 23);
        chk("preload_hours", tod() / 10000, 23);
        pulse(2, 1);
        pulse(1, 59);
        pulse(2, 1);
        chk("sec_clear", tod(), 235900);
        step(236);
        chk("at_235959", tod(), 235959);
        step(3);
        chk("hold_235959", tod(), 235959);
        chk("no_tick_mid", sec_tick, 0);
        step(1);
        chk("rollover_tod", tod(), 0);
        chk("rollover_tick", sec_tick, 1);

        // Minute set: no carry into hours, held button gives one step
        pulse(0, 12);
        pulse(1, 59);
        chk("at_1259", tod() / 100, 1259);
        pulse(1, 1);
        chk("min_wrap_nocarry", tod() / 100, 1200);
        min_btn = 1'b1;
        step(50);
        min_btn = 1'b0;
        step(2);
        chk("min_held_once", tod() / 100, 1201);

        // Hour set wraps and decade steps
        pulse(2, 1);
        pulse(0, 11);
        chk("hour_23", tod() / 10000, 23);
        pulse(0, 1);
        chk("hour_23_to_00", tod() / 10000, 0);
        pulse(0, 9);
        chk("hour_09", tod() / 10000, 9);
        pulse(0, 1);
        chk("hour_09_to_10", tod() / 10000, 10);
        pulse(0, 10);
        chk("hour_19_to_20", tod() / 10000, 20);
        chk("after_hours_tod", tod(), 200116);

        // Seconds clear in the same cycle as a tick
        pulse(2, 1);
        step(148);
        chk("at_xx37", tod(), 200137);
        step(2);
        sec_btn = 1'b1;
        step(1);
        sec_btn = 1'b0;
        step(1);
        chk("clr_vs_tick_tod", tod(), 200100);
        chk("clr_vs_tick_strobe", sec_tick, 0);
        step(3);
        chk("clr_no_early_tick", sec_tick, 0);
        step(1);
        chk("clr_next_tick", sec_tick, 1);
        chk("clr_next_tod", tod(), 200101);

        // Asynchronous reset mid-count, no edge needed
        reset = 1'b1;
        #1;
        chk("async_rst_tod", tod(), 0);
        chk("async_rst_tick", sec_tick, 0);
        step(1);
        reset = 1'b0;

        // Minute set coincident with a seconds carry
        pulse(1, 5);
        pulse(2, 1);
        step(236);
        chk("at_000559", tod(), 559);
        step(2);
        min_btn = 1'b1;
        step(1);
        min_btn = 1'b0;
        step(1);
        chk("min_set_with_carry", tod(), 600);
        chk("min_set_tick", sec_tick, 1);

        // Hour set coincident with a minute carry
        pulse(0, 3);
        pulse(1, 53);
        pulse(2, 1);
        step(236);
        chk("at_035959", tod(), 35959);
        step(2);
        hour_btn = 1'b1;
        step(1);
        hour_btn = 1'b0;
        step(1);
        chk("hour_set_with_carry", tod(), 40000);
        chk("hour_set_tick", sec_tick, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
